piso_shift_register: RTL and testbench
======================================

Name: piso_shift_register

Overview:
- Parallel-in/serial-out transmitter: the serial-side counterpart of the team's 32-bit PIPO register.
- Accepts a WIDTH-bit word through a valid/ready handshake, then shifts it out one bit per clock with a per-bit valid strobe.
- Sits between a PIPO register bank and a single-wire serial link; a matching SIPO receiver reassembles the word.

Parameters:
- WIDTH, 32, data word width in bits (≥2).
- LSB_FIRST, 1, 1 = shift bit 0 first; 0 = shift bit WIDTH-1 first.

Ports:
- clk  input  1  clock; all state updates on negative edge of clk (team flop convention).
- rst  input  1  reset, synchronous, active-high.
- din  input  WIDTH  parallel word to transmit.
- load_valid  input  1  din is valid.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- busy  output  1  word in transmission.
- done  output  1  one-cycle pulse concurrent with the final transmitted bit.

Behaviour:
- Reset:
  - rst sampled at negedge clk: state←IDLE, shift register←0, bit counter←0.
  - All outputs forced to 0 while rst is high: sout, sout_valid, busy, done, load_ready.
- State machine, two states:
  - IDLE → SHIFT when load_valid && load_ready at a clock edge.
  - SHIFT → IDLE after the last bit unless a new word is accepted in the same cycle.
- load_ready:
  - Combinational: !rst && (state==IDLE || last-bit cycle).
  - Asserted in the last-bit cycle so words can stream back-to-back with no gap bits.
- Accept edge:
  - shift register←din; counter←0.
  - Next cycle: first bit on sout, sout_valid=1, busy=1.
  - Latency: accept edge to first valid bit = 1 clock.
- Shifting:
  - Each SHIFT cycle outputs one bit; the register shifts right (LSB_FIRST=1) or left (LSB_FIRST=0) and the counter increments.
  - sout_valid is high for exactly WIDTH consecutive cycles per word.
- Counter: width $clog2(WIDTH+1); last-bit cycle is counter==WIDTH-1.
- done:
  - High only in the last-bit cycle, coincident with sout_valid.
  - Never asserted in IDLE.
- Back-to-back (load_valid high in last-bit cycle):
  - New word loaded at that edge; state stays SHIFT.
  - First bit of the new word appears on the next cycle.
  - sout_valid stays continuously high.
- Idle outputs: sout=0, sout_valid=0, busy=0.
- load_valid during SHIFT but not in the last-bit cycle: ignored (load_ready=0), din not sampled.
- din need not be held stable after the accept edge.
- Reset mid-word: transmission aborted at the reset edge, partial word discarded, no done pulse, block returns to IDLE.
- rst has priority over simultaneous load_valid.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra cycle transmits an even-parity bit (XOR of all WIDTH bits of the accepted word, latched at the accept edge).
  - sout_valid is high for WIDTH+1 cycles.
  - The last-bit cycle, done, and back-to-back load_ready move to the parity cycle.
  - Counter width becomes $clog2(WIDTH+2).
- Undefined: no parity cycle; behaviour exactly as above.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, load_valid=0 for 5 cycles → sout=0, sout_valid=0, busy=0, done=0; load_ready=0 during rst, 1 after.
- Single word, LSB_FIRST=1: din=32'hA5A5_0F01 accepted at edge N → bits at cycles N+1..N+32 = 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1. done only at N+32. Returns to IDLE at N+33.
- MSB_FIRST (LSB_FIRST=0): din=32'h8000_0001 → first bit 1, bits 2..31 = 0, bit 32 = 1; done at 32nd bit.
- Back-to-back: din=32'hFFFF_FFFF, then 32'h0000_0000 with load_valid held high → sout_valid high for 64 consecutive cycles; 32 ones then 32 zeros; done pulses at cycles 32 and 64; load_ready high only in cycles 32 and 64 and after.
- Reset mid-word: load 32'h1234_5678, assert rst after 10 bits → next cycle sout_valid=0, busy=0, no done. A subsequent word 32'h0000_0003 transmits correctly from its bit 0.
- PISO_PARITY_EN defined: din=32'h0000_0007 → 32 data bits then parity bit 1 (three ones); sout_valid for 33 cycles; done on cycle 33. din=32'h0000_0003 → parity bit 0.

Source files
------------

// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out transmitter: takes a WIDTH-bit word on a valid/ready handshake and shifts it out one bit per clock.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every word.
module piso_shift_register #(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  // Counter spans 0..NBITS-1; sized for NBITS+1 values so the top code stays spare.
  localparam int               CNT_W    = $clog2(NBITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBITS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             accept;
  logic             data_bit;
  logic             cur_bit;

  assign last_bit   = (state == SHIFT) && (cnt == LAST_CNT);
  // Ready again in the last-bit cycle so consecutive words stream with no gap.
  assign load_ready = !rst && ((state == IDLE) || last_bit);
  assign accept     = load_valid && load_ready;
  assign data_bit   = LSB_FIRST ? shreg[0] : shreg[WIDTH-1];

`ifdef PISO_PARITY_EN
  logic parity;

  assign cur_bit = last_bit ? parity : data_bit;

  always_ff @(negedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else if (accept) begin
      parity <= ^din;
    end
  end
`else
  assign cur_bit = data_bit;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      state <= SHIFT;
      shreg <= din;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      if (last_bit) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
        cnt   <= cnt + CNT_W'(1);
      end
    end
  end

  // Outputs come straight from state flops, held at zero while rst is high.
  assign sout_valid = !rst && (state == SHIFT);
  assign busy       = !rst && (state == SHIFT);
  assign done       = !rst && last_bit;
  assign sout       = !rst && (state == SHIFT) && cur_bit;

endmodule

// File: tb/tb_piso_shift_register.sv
// Scoreboard bench: two transmitters (LSB-first and MSB-first) share stimulus; a word-level model predicts bit streams and flags.
module tb_piso_shift_register;

  localparam int W = 32;
`ifdef PISO_PARITY_EN
  localparam int NBITS = W + 1;
`else
  localparam int NBITS = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         load_valid = 1'b0;

  logic load_ready_l, sout_l, sout_valid_l, busy_l, done_l;
  logic load_ready_m, sout_m, sout_valid_m, busy_m, done_m;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Model: bits still to send for the current word (0 = idle), and the expected serial streams.
  int   m_rem = 0;
  logic q_lsb[$];
  logic q_msb[$];

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(load_ready_l), .sout(sout_l), .sout_valid(sout_valid_l),
    .busy(busy_l), .done(done_l)
  );

  piso_shift_register #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid),
    .load_ready(load_ready_m), .sout(sout_m), .sout_valid(sout_valid_m),
    .busy(busy_m), .done(done_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus, applied just after the active (falling) edge.
  task automatic cycle(input logic r, input logic lv, input logic [W-1:0] d);
    @(negedge clk);
    #1;
    rst        = r;
    load_valid = lv;
    din        = d;
  endtask

  // Reference model: advances at the same edge the design does, from the inputs held over the cycle.
  always @(negedge clk) begin
    if (rst) begin
      m_rem = 0;
      q_lsb.delete();
      q_msb.delete();
    end else if (load_valid && m_rem <= 1) begin
      for (int i = 0; i < W; i++) begin
        q_lsb.push_back(din[i]);
        q_msb.push_back(din[W-1-i]);
      end
`ifdef PISO_PARITY_EN
      q_lsb.push_back(^din);
      q_msb.push_back(^din);
`endif
      m_rem = NBITS;
    end else if (m_rem > 0) begin
      m_rem = m_rem - 1;
    end
  end

  // Monitor: samples mid-cycle, away from the falling edge.
  always @(posedge clk) begin
    logic [3:0] exp_flags;
    logic       exp_b;
    if (mon_en) begin
      exp_flags = {!rst && (m_rem > 0), !rst && (m_rem > 0),
                   !rst && (m_rem == 1), !rst && (m_rem <= 1)};
      check("flags_lsb{valid,busy,done,ready}",
            32'({sout_valid_l, busy_l, done_l, load_ready_l}), 32'(exp_flags));
      check("flags_msb{valid,busy,done,ready}",
            32'({sout_valid_m, busy_m, done_m, load_ready_m}), 32'(exp_flags));
      if (sout_valid_l) begin
        exp_b = (q_lsb.size() > 0) ? q_lsb.pop_front() : 1'bx;
        check("bit_lsb", 32'(sout_l), 32'(exp_b));
      end else begin
        check("idle_sout_lsb", 32'(sout_l), 32'd0);
      end
      if (sout_valid_m) begin
        exp_b = (q_msb.size() > 0) ? q_msb.pop_front() : 1'bx;
        check("bit_msb", 32'(sout_m), 32'(exp_b));
      end else begin
        check("idle_sout_msb", 32'(sout_m), 32'd0);
      end
    end
  end

  initial begin
    // Reset for two cycles; load_valid during reset must be ignored.
    cycle(1'b1, 1'b0, '0);
    mon_en = 1'b1;
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF);
    repeat (5) cycle(1'b0, 1'b0, '0);

    // Single word, then idle long enough to return to IDLE.
    cycle(1'b0, 1'b1, 32'hA5A5_0F01);
    repeat (NBITS + 3) cycle(1'b0, 1'b0, 32'hFFFF_FFFF);

    // First and last bits set, everything between clear.
    cycle(1'b0, 1'b1, 32'h8000_0001);
    repeat (NBITS + 3) cycle(1'b0, 1'b0, '0);

    // Back-to-back: second word offered throughout the first word's transmission.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (NBITS) cycle(1'b0, 1'b1, 32'h0000_0000);
    repeat (NBITS + 3) cycle(1'b0, 1'b0, '0);

    // Reset after ten bits, then a fresh word from its bit 0.
    cycle(1'b0, 1'b1, 32'h1234_5678);
    repeat (10) cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h0000_0003);
    repeat (NBITS + 3) cycle(1'b0, 1'b0, '0);

    // Parity cases (odd and even weight); plain words when parity is off.
    cycle(1'b0, 1'b1, 32'h0000_0007);
    repeat (NBITS + 2) cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b1, 32'h0000_0003);
    repeat (NBITS + 2) cycle(1'b0, 1'b0, '0);

    // Random traffic: din changes every cycle, sporadic valid and reset.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), $urandom);
    end
    repeat (NBITS + 5) cycle(1'b0, 1'b0, '0);

    check("drain_lsb", 32'(q_lsb.size()), 32'd0);
    check("drain_msb", 32'(q_msb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
